// File: rtl/controller_pkg.sv
// Shared button definitions for consumers of the controller receiver.
package controller_pkg;

  localparam int NUM_BUTTONS = 12;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_X      = 8;
  localparam int BTN_Y      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  localparam logic [NUM_BUTTONS-1:0] DIR_MASK = 12'b0000_1111_0000;

  typedef logic [NUM_BUTTONS-1:0] btn_vec_t;

endpackage

// File: rtl/dir_repeat_ctr.sv
// Auto-repeat counter for one D-pad direction: pulses at held-frames D, D+P, D+2P, ...
module dir_repeat_ctr #(
  parameter int unsigned REPEAT_DELAY  = 20,
  parameter int unsigned REPEAT_PERIOD = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic press,
  input  logic held,
  output logic pulse
);

  logic [7:0] cnt;
  logic [7:0] cnt_inc;

  assign cnt_inc = cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (tick) begin
        if (press || !held) begin
          cnt <= '0;
        end else if (cnt_inc == 8'(REPEAT_DELAY)) begin
          // Reload so the next pulse lands exactly REPEAT_PERIOD ticks later.
          cnt   <= 8'(REPEAT_DELAY - REPEAT_PERIOD);
          pulse <= 1'b1;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: rtl/button_event_gen.sv
// Frame-sampled button events: held levels, edge pulses, latched press mask, D-pad repeat.
// Optional BTN_DEBOUNCE_EN: a bit changes only after two equal consecutive samples.
module button_event_gen
  import controller_pkg::*;
#(
  parameter int unsigned CONNECT_FRAMES = 4,
  parameter int unsigned REPEAT_DELAY   = 20,
  parameter int unsigned REPEAT_PERIOD  = 6
) (
  input  logic                   system_clk_25MHz,
  input  logic                   rst_n,
  input  logic                   frame_tick,
  input  logic [NUM_BUTTONS-1:0] buttons_in,
  input  logic                   controller_status,
  output logic                   connected,
  output logic [NUM_BUTTONS-1:0] btn_held,
  output logic [NUM_BUTTONS-1:0] btn_pressed,
  output logic [NUM_BUTTONS-1:0] btn_released,
  output logic [3:0]             dir_repeat,
  output logic                   event_valid,
  output logic [NUM_BUTTONS-1:0] event_mask,
  input  logic                   event_ack
);

  logic [7:0] conn_cnt;
  logic [7:0] conn_cnt_next;
  logic       connected_next;
  btn_vec_t   sampled;
  btn_vec_t   eff;
  btn_vec_t   new_press;
  btn_vec_t   mask_next;

  always_comb begin
    conn_cnt_next = conn_cnt;
    if (!controller_status) begin
      conn_cnt_next = '0;
    end else if (conn_cnt != 8'(CONNECT_FRAMES)) begin
      conn_cnt_next = conn_cnt + 8'd1;
    end
  end

  assign connected_next = (conn_cnt_next == 8'(CONNECT_FRAMES));

`ifdef BTN_DEBOUNCE_EN
  btn_vec_t prev_sample;
  btn_vec_t unstable;

  always_ff @(posedge system_clk_25MHz) begin
    if (!rst_n) begin
      prev_sample <= '0;
    end else if (frame_tick) begin
      prev_sample <= buttons_in;
    end
  end

  assign unstable = buttons_in ^ prev_sample;
  assign sampled  = (buttons_in & ~unstable) | (btn_held & unstable);
`else
  assign sampled = buttons_in;
`endif

  assign eff       = connected_next ? sampled : '0;
  assign new_press = eff & ~btn_held;

  // Ack and tick together: old content is consumed, this tick's presses survive.
  always_comb begin
    mask_next = event_mask;
    if (event_ack && event_valid) begin
      mask_next = frame_tick ? new_press : '0;
    end else if (frame_tick) begin
      mask_next = event_mask | new_press;
    end
  end

  always_ff @(posedge system_clk_25MHz) begin
    if (!rst_n) begin
      conn_cnt     <= '0;
      connected    <= 1'b0;
      btn_held     <= '0;
      btn_pressed  <= '0;
      btn_released <= '0;
      event_mask   <= '0;
      event_valid  <= 1'b0;
    end else begin
      btn_pressed  <= '0;
      btn_released <= '0;
      event_mask   <= mask_next;
      event_valid  <= |mask_next;
      if (frame_tick) begin
        conn_cnt     <= conn_cnt_next;
        connected    <= connected_next;
        btn_held     <= eff;
        btn_pressed  <= new_press;
        btn_released <= ~eff & btn_held;
      end
    end
  end

  for (genvar d = 0; d < 4; d++) begin : g_dir
    dir_repeat_ctr #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ctr (
      .clk  (system_clk_25MHz),
      .rst_n(rst_n),
      .tick (frame_tick),
      .press(new_press[BTN_UP + d]),
      .held (eff[BTN_UP + d]),
      .pulse(dir_repeat[d])
    );
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed plus randomized bench for button_event_gen against a frame-level reference model.
module tb_button_event_gen;
  import controller_pkg::*;

  localparam int CF = 4;
  localparam int RD = 20;
  localparam int RP = 6;

  logic     system_clk_25MHz = 1'b0;
  logic     rst_n = 1'b0;
  logic     frame_tick = 1'b0;
  logic     controller_status = 1'b0;
  logic     event_ack = 1'b0;
  btn_vec_t buttons_in = '0;

  logic       connected;
  btn_vec_t   btn_held, btn_pressed, btn_released, event_mask;
  logic [3:0] dir_repeat;
  logic       event_valid;

  always #20 system_clk_25MHz = ~system_clk_25MHz;

  button_event_gen #(
    .CONNECT_FRAMES(CF),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .system_clk_25MHz (system_clk_25MHz),
    .rst_n            (rst_n),
    .frame_tick       (frame_tick),
    .buttons_in       (buttons_in),
    .controller_status(controller_status),
    .connected        (connected),
    .btn_held         (btn_held),
    .btn_pressed      (btn_pressed),
    .btn_released     (btn_released),
    .dir_repeat       (dir_repeat),
    .event_valid      (event_valid),
    .event_mask       (event_mask),
    .event_ack        (event_ack)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: frame-level quantities, not RTL counters.
  int         m_conn;
  btn_vec_t   m_held, m_pr, m_rl, m_mask, m_prev;
  logic [3:0] m_rep;
  int         m_hf[4];

  task automatic chk(string tag, logic [11:0] got, logic [11:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_step(logic r, logic t, logic s, btn_vec_t b, logic a);
    btn_vec_t cand, eff;
    if (!r) begin
      m_conn = 0; m_held = '0; m_pr = '0; m_rl = '0; m_mask = '0; m_prev = '0; m_rep = '0;
      for (int d = 0; d < 4; d++) m_hf[d] = 0;
    end else if (t) begin
      m_conn = s ? ((m_conn < CF) ? m_conn + 1 : CF) : 0;
      cand = b;
`ifdef BTN_DEBOUNCE_EN
      for (int i = 0; i < NUM_BUTTONS; i++) cand[i] = (b[i] == m_prev[i]) ? b[i] : m_held[i];
      m_prev = b;
`endif
      eff  = (m_conn == CF) ? cand : '0;
      m_pr = eff & ~m_held;
      m_rl = ~eff & m_held;
      for (int d = 0; d < 4; d++) begin
        m_rep[d] = 1'b0;
        if (m_pr[BTN_UP + d]) m_hf[d] = 0;
        else if (eff[BTN_UP + d]) begin
          m_hf[d]++;
          m_rep[d] = (m_hf[d] >= RD) && ((m_hf[d] - RD) % RP == 0);
        end else m_hf[d] = 0;
      end
      m_held = eff;
      if (a && m_mask != '0) m_mask = m_pr;
      else m_mask = m_mask | m_pr;
    end else begin
      m_pr = '0; m_rl = '0; m_rep = '0;
      if (a && m_mask != '0) m_mask = '0;
    end
  endtask

  task automatic check_all();
    chk("connected", {11'b0, connected}, {11'b0, m_conn == CF});
    chk("btn_held", btn_held, m_held);
    chk("btn_pressed", btn_pressed, m_pr);
    chk("btn_released", btn_released, m_rl);
    chk("dir_repeat", {8'b0, dir_repeat}, {8'b0, m_rep});
    chk("event_valid", {11'b0, event_valid}, {11'b0, m_mask != '0});
    chk("event_mask", event_mask, m_mask);
  endtask

  task automatic step(logic r, logic t, logic s, btn_vec_t b, logic a);
    @(negedge system_clk_25MHz);
    rst_n = r; frame_tick = t; controller_status = s; buttons_in = b; event_ack = a;
    @(posedge system_clk_25MHz);
    model_step(r, t, s, b, a);
    #1;
    check_all();
  endtask

  btn_vec_t cur;
  btn_vec_t rnd;

  initial begin
    // Reset
    step(0, 0, 0, '0, 0);
    step(0, 1, 1, 12'h001, 0);
    chk("rst_conn", {11'b0, connected}, 12'h000);
    chk("rst_held", btn_held, 12'h000);
    chk("rst_mask", event_mask, 12'h000);

    // Connect debounce with A held
    for (int k = 1; k <= 3; k++) begin
      step(1, 1, 1, 12'h001, 0);
      chk("conn_early", {11'b0, connected}, 12'h000);
      chk("held_early", btn_held, 12'h000);
      step(1, 0, 1, 12'h001, 0);
    end
    step(1, 1, 1, 12'h001, 0);
    chk("conn_t4", {11'b0, connected}, 12'h001);
    chk("held_t4", btn_held, 12'h001);
    chk("pressed_t4", btn_pressed, 12'h001);
    chk("valid_t4", {11'b0, event_valid}, 12'h001);
    step(1, 0, 1, 12'h001, 0);
    chk("pressed_1cyc", btn_pressed, 12'h000);
    step(1, 0, 1, 12'h001, 1);
    chk("ack_clear", event_mask, 12'h000);

    // Disconnect with A and up held
    step(1, 1, 1, 12'h011, 0);
    step(1, 1, 1, 12'h011, 0);
    step(1, 1, 0, 12'h011, 0);
    chk("disc_conn", {11'b0, connected}, 12'h000);
    chk("disc_rel", btn_released, 12'h011);
    chk("disc_held", btn_held, 12'h000);
    step(1, 0, 0, 12'h011, 0);
    chk("disc_rel_1cyc", btn_released, 12'h000);
    step(1, 0, 1, '0, 1);

    // Reconnect, then accumulate B and start
    for (int k = 0; k < CF; k++) step(1, 1, 1, '0, 0);
    step(1, 0, 1, '0, 1);
    step(1, 1, 1, 12'h002, 0);
    step(1, 1, 1, 12'h00A, 0);
    step(1, 1, 1, 12'h00A, 0);
`ifndef BTN_DEBOUNCE_EN
    chk("accum_mask", event_mask, 12'h00A);
`endif
    step(1, 0, 1, 12'h00A, 1);
    chk("accum_ack_mask", event_mask, 12'h000);
    chk("accum_ack_valid", {11'b0, event_valid}, 12'h000);

    // Simultaneous ack and tick
    step(1, 1, 1, '0, 0);
    step(1, 1, 1, '0, 0);
    step(1, 1, 1, 12'h001, 0);
    step(1, 1, 1, 12'h001, 0);
    step(1, 1, 1, 12'h101, 1);
`ifndef BTN_DEBOUNCE_EN
    chk("simul_mask", event_mask, 12'h100);
`endif

    // Auto-repeat on right
    step(1, 1, 1, '0, 1);
    step(1, 1, 1, '0, 1);
    for (int rep = 0; rep < 2; rep++) begin
      step(1, 1, 1, 12'h080, 0);
      for (int k = 1; k <= 33; k++) begin
        step(1, 1, 1, 12'h080, 0);
`ifndef BTN_DEBOUNCE_EN
        chk("repeat_pulse", {11'b0, dir_repeat[3]}, {11'b0, (k == 20 || k == 26 || k == 32)});
`endif
        step(1, 0, 1, 12'h080, 0);
      end
      for (int k = 0; k < 10; k++) step(1, 1, 1, '0, 0);
    end

    // Reset mid-hold
    step(1, 1, 1, 12'h0F3, 0);
    step(1, 1, 1, 12'h0F3, 0);
    step(0, 1, 1, 12'h0F3, 0);
    chk("rstmid_held", btn_held, 12'h000);
    chk("rstmid_mask", event_mask, 12'h000);
    for (int k = 1; k <= CF; k++) begin
      step(1, 1, 1, 12'h0F3, 0);
      chk("rstmid_conn", {11'b0, connected}, {11'b0, k == CF});
    end

    // Randomized: long holds, glitches between ticks, rare disconnects and resets
    cur = '0;
    for (int n = 0; n < 4000; n++) begin
      logic t, s, a, r;
      t = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 15) != 0);
      a = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 599) != 0);
      if (t)
        for (int i = 0; i < NUM_BUTTONS; i++)
          if ($urandom_range(0, 47) == 0) cur[i] = ~cur[i];
      rnd = btn_vec_t'($urandom);
      step(r, t, s, (!t && $urandom_range(0, 3) == 0) ? rnd : cur, a);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
